// File: rtl/sort_pkg.sv
// Shared width helpers, FSM encoding and verdict type for the sort output checker.
package sort_pkg;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < value) begin
            r++;
        end
        return r;
    endfunction

    function automatic int unsigned cnt_w(input int unsigned size);
        return clog2(size) + 1;
    endfunction

    function automatic int unsigned sum_w(input int unsigned size, input int unsigned width);
        return width + cnt_w(size);
    endfunction

    typedef enum logic [1:0] {StIdle, StRun, StCheck} out_state_e;

    typedef struct packed {
        logic order;
        logic count;
        logic sum;
        logic minmax;
    } verdict_t;

endpackage

// File: rtl/sort_stream_stats.sv
// Per-frame stream statistics: count, sum, min/max, first/last word and order violation.
module sort_stream_stats #(
    parameter int unsigned WIDTH = 12,
    parameter int unsigned CNT_W = 11,
    parameter int unsigned SUM_W = 23
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid,
    input  logic [WIDTH-1:0] data,
    input  logic             clear,
    output logic [CNT_W-1:0] count,
    output logic [SUM_W-1:0] sum,
    output logic [WIDTH-1:0] min,
    output logic [WIDTH-1:0] max,
    output logic [WIDTH-1:0] first,
    output logic [WIDTH-1:0] last,
    output logic             order_bad
);

    logic [CNT_W-1:0] count_q, count_d;
    logic [SUM_W-1:0] sum_q, sum_d;
    logic [WIDTH-1:0] min_q, min_d, max_q, max_d, first_q, first_d, last_q, last_d;
    logic             order_q, order_d;

    always_comb begin
        count_d = count_q;
        sum_d   = sum_q;
        min_d   = min_q;
        max_d   = max_q;
        first_d = first_q;
        last_d  = last_q;
        order_d = order_q;
        if (clear) begin
            count_d = '0;
            sum_d   = '0;
            min_d   = '0;
            max_d   = '0;
            first_d = '0;
            last_d  = '0;
            order_d = 1'b0;
        end
        if (valid) begin
            // A word arriving on the clear cycle starts the next frame.
            if (clear || count_q == '0) begin
                count_d = CNT_W'(1);
                sum_d   = SUM_W'(data);
                min_d   = data;
                max_d   = data;
                first_d = data;
                last_d  = data;
                order_d = 1'b0;
            end else begin
                if (count_q != '1) count_d = count_q + CNT_W'(1);
                sum_d   = sum_q + SUM_W'(data);
                if (data < min_q) min_d = data;
                if (data > max_q) max_d = data;
                last_d  = data;
                order_d = order_q | (data < last_q);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            sum_q   <= '0;
            min_q   <= '0;
            max_q   <= '0;
            first_q <= '0;
            last_q  <= '0;
            order_q <= 1'b0;
        end else begin
            count_q <= count_d;
            sum_q   <= sum_d;
            min_q   <= min_d;
            max_q   <= max_d;
            first_q <= first_d;
            last_q  <= last_d;
            order_q <= order_d;
        end
    end

    assign count     = count_q;
    assign sum       = sum_q;
    assign min       = min_q;
    assign max       = max_q;
    assign first     = first_q;
    assign last      = last_q;
    assign order_bad = order_q;

endmodule

// File: rtl/sort_checker.sv
// Verifies each sorter output frame against stats gathered from the matching input frame.
module sort_checker
    import sort_pkg::*;
#(
    parameter int unsigned SIZE  = 1024,
    parameter int unsigned WIDTH = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    input  logic             active_input,
    input  logic [WIDTH-1:0] q,
    input  logic             active_output,
    output logic             frame_done,
    output logic             frame_ok,
    output logic             err_order,
    output logic             err_count,
    output logic             err_sum,
    output logic             err_minmax,
    output logic             overrun,
    output logic [15:0]      frames_total,
    output logic [15:0]      frames_bad
);

    localparam int unsigned CntW = cnt_w(SIZE);
    localparam int unsigned SumW = sum_w(SIZE, WIDTH);

    logic [CntW-1:0]  in_count, out_count;
    logic [SumW-1:0]  in_sum, out_sum;
    logic [WIDTH-1:0] in_min, in_max, in_first, in_last;
    logic [WIDTH-1:0] out_min, out_max, out_first, out_last;
    logic             in_order_bad, out_order_bad;

    logic             active_in_q, in_close, out_clear;
    out_state_e       state_q, state_d;
    logic             pend_valid_q, pend_valid_d;
    logic [SumW-1:0]  pend_sum_q;
    logic [WIDTH-1:0] pend_min_q, pend_max_q;
    verdict_t         verdict_q, verdict_d;
    logic             done_q, ok_q, overrun_q, overrun_d;
    logic [15:0]      total_q, bad_q;

    assign in_close  = active_in_q & ~active_input;
    assign out_clear = (state_q == StCheck);

    sort_stream_stats #(.WIDTH(WIDTH), .CNT_W(CntW), .SUM_W(SumW)) u_in_stats (
        .clk(clk), .rst_n(rst_n), .valid(active_input), .data(d), .clear(in_close),
        .count(in_count), .sum(in_sum), .min(in_min), .max(in_max),
        .first(in_first), .last(in_last), .order_bad(in_order_bad)
    );

    sort_stream_stats #(.WIDTH(WIDTH), .CNT_W(CntW), .SUM_W(SumW)) u_out_stats (
        .clk(clk), .rst_n(rst_n), .valid(active_output), .data(q), .clear(out_clear),
        .count(out_count), .sum(out_sum), .min(out_min), .max(out_max),
        .first(out_first), .last(out_last), .order_bad(out_order_bad)
    );

    logic unused_stats;
    assign unused_stats = ^{in_count, in_first, in_last, in_order_bad, out_min, out_max};

    always_comb begin
        state_d      = state_q;
        verdict_d    = '0;
        pend_valid_d = pend_valid_q;
        overrun_d    = overrun_q;

        unique case (state_q)
            StIdle:  if (active_output) state_d = StRun;
            StRun:   if (!active_output) state_d = StCheck;
            StCheck: state_d = active_output ? StRun : StIdle;
            default: state_d = StIdle;
        endcase

        verdict_d.order = out_order_bad;
        if (pend_valid_q) begin
            verdict_d.count  = (out_count != CntW'(SIZE));
            verdict_d.sum    = (out_sum != pend_sum_q);
            verdict_d.minmax = (out_first != pend_min_q) || (out_last != pend_max_q);
        end else begin
            verdict_d.count  = 1'b1;
        end

        // CHECK reads the old bank; a same-cycle close refills it without overrun.
        if (out_clear) pend_valid_d = 1'b0;
        if (in_close) begin
            pend_valid_d = 1'b1;
            if (pend_valid_q && !out_clear) overrun_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_in_q  <= 1'b0;
            state_q      <= StIdle;
            pend_valid_q <= 1'b0;
            pend_sum_q   <= '0;
            pend_min_q   <= '0;
            pend_max_q   <= '0;
            verdict_q    <= '0;
            done_q       <= 1'b0;
            ok_q         <= 1'b0;
            overrun_q    <= 1'b0;
            total_q      <= '0;
            bad_q        <= '0;
        end else begin
            active_in_q  <= active_input;
            state_q      <= state_d;
            pend_valid_q <= pend_valid_d;
            overrun_q    <= overrun_d;
            done_q       <= out_clear;
            if (in_close) begin
                pend_sum_q <= in_sum;
                pend_min_q <= in_min;
                pend_max_q <= in_max;
            end
            if (out_clear) begin
                verdict_q <= verdict_d;
                ok_q      <= ~|verdict_d;
                total_q   <= total_q + 16'd1;
                if (|verdict_d) bad_q <= bad_q + 16'd1;
            end
        end
    end

    assign frame_done   = done_q;
    assign frame_ok     = ok_q;
    assign err_order    = verdict_q.order;
    assign err_count    = verdict_q.count;
    assign err_sum      = verdict_q.sum;
    assign err_minmax   = verdict_q.minmax;
    assign overrun      = overrun_q;
    assign frames_total = total_q;
    assign frames_bad   = bad_q;

endmodule

// File: tb/tb_sort_checker.sv
// Self-checking bench for sort_checker: vector table, verdict scoreboard, reset and overrun sequences.
module tb_sort_checker;

    localparam int unsigned SIZE  = 8;
    localparam int unsigned WIDTH = 12;

    typedef logic [7:0][WIDTH-1:0] frame_t;
    typedef struct packed {
        logic ok;
        logic order;
        logic count;
        logic sum;
        logic minmax;
    } exp_t;
    typedef struct packed {
        frame_t din;
        int     n_in;
        frame_t dout;
        int     n_out;
        exp_t   exp;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [WIDTH-1:0] d, q;
    logic             active_input, active_output;
    logic             frame_done, frame_ok, err_order, err_count, err_sum, err_minmax, overrun;
    logic [15:0]      frames_total, frames_bad;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   exp_total = 0;
    int   exp_bad = 0;
    exp_t sb_q[$];
    exp_t mon_e;
    vec_t vecs[6];

    always #5 clk = ~clk;

    sort_checker #(.SIZE(SIZE), .WIDTH(WIDTH)) dut (
        .clk(clk), .rst_n(rst_n), .d(d), .active_input(active_input), .q(q),
        .active_output(active_output), .frame_done(frame_done), .frame_ok(frame_ok),
        .err_order(err_order), .err_count(err_count), .err_sum(err_sum),
        .err_minmax(err_minmax), .overrun(overrun), .frames_total(frames_total),
        .frames_bad(frames_bad)
    );

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic frame_t pack8(input int a0, a1, a2, a3, a4, a5, a6, a7);
        frame_t r;
        r[0] = WIDTH'(a0); r[1] = WIDTH'(a1); r[2] = WIDTH'(a2); r[3] = WIDTH'(a3);
        r[4] = WIDTH'(a4); r[5] = WIDTH'(a5); r[6] = WIDTH'(a6); r[7] = WIDTH'(a7);
        return r;
    endfunction

    function automatic exp_t mk_exp(input logic ok, o, c, s, m);
        exp_t e;
        e.ok = ok; e.order = o; e.count = c; e.sum = s; e.minmax = m;
        return e;
    endfunction

    // Scoreboard: every verdict pulse consumes one expected record.
    always @(negedge clk) begin
        if (rst_n && frame_done) begin
            if (sb_q.size() == 0) begin
                check("unexpected_frame_done", 1, 0);
            end else begin
                mon_e = sb_q.pop_front();
                exp_total++;
                if (!mon_e.ok) exp_bad++;
                check("frame_ok", int'(frame_ok), int'(mon_e.ok));
                check("err_order", int'(err_order), int'(mon_e.order));
                check("err_count", int'(err_count), int'(mon_e.count));
                check("err_sum", int'(err_sum), int'(mon_e.sum));
                check("err_minmax", int'(err_minmax), int'(mon_e.minmax));
                check("frames_total", int'(frames_total), exp_total);
                check("frames_bad", int'(frames_bad), exp_bad);
            end
        end
    end

    task automatic drive_in(input frame_t w, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            d = w[i];
            active_input = 1'b1;
        end
        @(negedge clk);
        active_input = 1'b0;
        d = '0;
    endtask

    task automatic drive_out(input frame_t w, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            q = w[i];
            active_output = 1'b1;
        end
        @(negedge clk);
        active_output = 1'b0;
        q = '0;
    endtask

    task automatic wait_verdict(output int lat);
        lat = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (frame_done) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic run_vec(input vec_t v);
        int lat;
        if (v.n_in > 0) drive_in(v.din, v.n_in);
        repeat (2) @(negedge clk);
        sb_q.push_back(v.exp);
        drive_out(v.dout, v.n_out);
        wait_verdict(lat);
        check("verdict_latency", lat, 2);
        #1;
        check("sb_drained", sb_q.size(), 0);
        sb_q.delete();
    endtask

    initial begin
        frame_t in_a, out_sorted;
        in_a       = pack8(10, 7, 15, 12, 20, 17, 25, 22);
        out_sorted = pack8(7, 10, 12, 15, 17, 20, 22, 25);
        vecs[0] = '{din: in_a, n_in: 8, dout: out_sorted, n_out: 8,
                    exp: mk_exp(1'b1, 1'b0, 1'b0, 1'b0, 1'b0)};
        vecs[1] = '{din: in_a, n_in: 8, dout: pack8(7, 10, 15, 12, 17, 20, 22, 25), n_out: 8,
                    exp: mk_exp(1'b0, 1'b1, 1'b0, 1'b0, 1'b0)};
        vecs[2] = '{din: in_a, n_in: 8, dout: out_sorted, n_out: 7,
                    exp: mk_exp(1'b0, 1'b0, 1'b1, 1'b1, 1'b1)};
        vecs[3] = '{din: in_a, n_in: 8, dout: pack8(7, 10, 12, 15, 17, 20, 22, 26), n_out: 8,
                    exp: mk_exp(1'b0, 1'b0, 1'b0, 1'b1, 1'b1)};
        vecs[4] = '{din: pack8(5, 5, 5, 5, 5, 5, 5, 5), n_in: 8,
                    dout: pack8(5, 5, 5, 5, 5, 5, 5, 5), n_out: 8,
                    exp: mk_exp(1'b1, 1'b0, 1'b0, 1'b0, 1'b0)};
        vecs[5] = '{din: in_a, n_in: 0, dout: out_sorted, n_out: 8,
                    exp: mk_exp(1'b0, 1'b0, 1'b1, 1'b0, 1'b0)};

        rst_n = 1'b0;
        d = '0;
        q = '0;
        active_input = 1'b0;
        active_output = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_frame_done", int'(frame_done), 0);
        check("reset_frame_ok", int'(frame_ok), 0);
        check("reset_errs", int'({err_order, err_count, err_sum, err_minmax}), 0);
        check("reset_overrun", int'(overrun), 0);
        check("reset_frames_total", int'(frames_total), 0);
        check("reset_frames_bad", int'(frames_bad), 0);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);
        check("no_overrun", int'(overrun), 0);

        // Reset in the middle of an output frame.
        drive_in(in_a, 8);
        repeat (2) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            q = out_sorted[i];
            active_output = 1'b1;
        end
        @(negedge clk);
        rst_n = 1'b0;
        active_output = 1'b0;
        #1;
        check("async_rst_frames_total", int'(frames_total), 0);
        check("async_rst_frames_bad", int'(frames_bad), 0);
        check("async_rst_err_count", int'(err_count), 0);
        check("async_rst_frame_done", int'(frame_done), 0);
        sb_q.delete();
        exp_total = 0;
        exp_bad = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run_vec(vecs[0]);
        check("post_rst_frames_total", int'(frames_total), 1);
        check("post_rst_frame_ok", int'(frame_ok), 1);

        // Two input frames with no output frame between them.
        drive_in(in_a, 8);
        drive_in(in_a, 8);
        repeat (2) @(negedge clk);
        check("overrun_set", int'(overrun), 1);
        repeat (3) @(negedge clk);
        check("overrun_sticky", int'(overrun), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sort_checker.md
Name: sort_checker

Overview:
- Synthesizable stream checker at the output end of the systolic `sort` block.
- Snoops the sorter input stream (`d`/`active_input`) and the output stream (`q`/`active_output`) and verifies each output frame.
- Checks applied per frame: ascending order, word count, checksum, min and max.
- Reports per-frame pass/fail and running totals, for on-board self-test and for simulation.

Parameters:
- SIZE, 1024, words per sort frame
- WIDTH, 12, data word width

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- d  in  WIDTH  sorter input word, valid while active_input=1
- active_input  in  1  sorter input-phase flag
- q  in  WIDTH  sorter output word, valid while active_output=1
- active_output  in  1  sorter output-phase flag
- frame_done  out  1  one-cycle pulse: output frame verdict valid
- frame_ok  out  1  last verdict passed (held until next verdict)
- err_order  out  1  last frame had q[i] < q[i-1]
- err_count  out  1  last frame word count != SIZE, or no pending input frame
- err_sum  out  1  output sum != input sum
- err_minmax  out  1  first q != input min, or last q != input max
- overrun  out  1  sticky: input frame completed while previous stats still pending
- frames_total  out  16  verdicts issued, wraps at 65535->0
- frames_bad  out  16  failed verdicts, wraps

Behaviour:
- Reset (async assert, sync release): all outputs 0, both accumulators cleared, pending-valid cleared, FSM to IDLE.
- Input side: every clk with active_input=1 accumulates d:
  - count, width CNT_W = clog2(SIZE)+1, saturating at all-ones;
  - sum, width SUM_W = WIDTH+CNT_W, unsigned, no wrap possible at count<=SIZE;
  - running min and max.
- Input frame close: at the first clk where active_input=0 after a 1:
  - stats copy to the pending bank and pending_valid is set;
  - the accumulator clears in the same cycle.
  - If pending_valid was already 1 and not consumed that cycle, overrun sets (sticky until reset) and the new stats overwrite the pending bank.
- Output FSM:
  - IDLE: active_output=1 -> RUN. The first word is accumulated in that same cycle: count=1, sum=q, first=q, prev=q.
  - RUN: each active_output=1 cycle:
    - count++ (saturating), sum+=q;
    - order_bad |= (q < prev);
    - prev<=q.
  - RUN: active_output=0 -> CHECK.
  - CHECK (one cycle): compare the output stats against the pending bank.
    - Register frame_done=1 and the err_* flags.
    - frame_ok = no err.
    - frames_total++; frames_bad++ if !frame_ok.
    - Clear pending_valid and the output accumulator.
    - Return to IDLE. If active_output=1 in CHECK, go straight to RUN and accumulate that word as the first.
- Verdict latency: frame_done is high in the cycle after the first active_output=0 sample following an output frame, i.e. 2 clk edges after the last valid q is sampled.
- Comparison rules:
  - Equal neighbours are legal.
  - err_minmax uses the first and last sampled q.
  - If no pending frame is valid at CHECK: err_count=1, err_sum=0, err_minmax=0.
- Simultaneous events:
  - Input close and CHECK consume in the same cycle: CHECK uses the old pending bank, then the new stats load; no overrun.
  - active_input and active_output both high: the two sides run independently.
- Mid-frame reset discards all partial stats; the next complete input+output pair checks normally.

Decomposition:
- Package sort_pkg:
  - function clog2;
  - constants CNT_W(SIZE) and SUM_W(SIZE,WIDTH);
  - FSM state encoding IDLE/RUN/CHECK;
  - verdict struct {order,count,sum,minmax}.
- Sub-module sort_stream_stats (clk, rst_n, valid, data, clear -> count, sum, min, max, first, last, order_bad), instantiated twice: input side with order check ignored, output side.

Test Plan (SIZE=8, WIDTH=12):
- In 10,7,15,12,20,17,25,22; out 7,10,12,15,17,20,22,25 -> frame_done 1 cycle, frame_ok=1, all err=0, frames_total=1, frames_bad=0.
- Same input; out 7,10,15,12,17,20,22,25 -> err_order=1, err_sum=0, err_minmax=0, frame_ok=0, frames_bad=1.
- Same input; out only 7 words (25 dropped) -> err_count=1, err_sum=1, err_minmax=1.
- Same input; out last word 26 -> err_sum=1, err_minmax=1, err_order=0, err_count=0.
- Eight inputs all 5, output eight 5s -> frame_ok=1. Output frame with no preceding input frame -> err_count=1.
- Assert rst_n=0 after 4 output words -> all outputs 0 asynchronously. Then a full valid pair -> frame_ok=1, frames_total=1. Two input frames back-to-back before output -> overrun=1.
